// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding, tag width and address helpers for cache_ctrl
package cache_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;
  function automatic int tag_w(input int depth);
    return 30 - depth;
  endfunction
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: direct-mapped tag/valid/data arrays with combinational lookup and one write port
module cache_line_store
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [29:0]      word,
  output logic             hit,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata
);
  localparam int TW = tag_w(DEPTH);
  logic [TW-1:0]       tags  [2**DEPTH];
  logic [WIDTH-1:0]    data  [2**DEPTH];
  logic [2**DEPTH-1:0] valid;
  logic [DEPTH-1:0]    idx;
  logic [TW-1:0]       tag;
  assign idx   = word[DEPTH-1:0];
  assign tag   = word[29:DEPTH];
  assign hit   = valid[idx] && (tags[idx] == tag);
  assign rdata = data[idx];
  // flush beats a same-cycle refill so the line stays invalid
  always_ff @(posedge clk) begin
    if (rst || flush) valid <= '0;
    else if (we) valid[idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= tag;
      data[idx] <= wdata;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-through, no-write-allocate miss/refill controller with miss counter
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [15:0]      miss_cnt
);
  state_t           state;
  logic             hit;
  logic             store_we;
  logic [29:0]      look;
  logic [WIDTH-1:0] store_wdata;
  logic             unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];
  // mem_addr doubles as the latched address while a transaction is open
  assign look        = (state == IDLE) ? cpu_addr[31:2] : mem_addr[31:2];
  assign store_we    = mem_ack && ((state == REFILL) || (state == WRITE && hit));
  assign store_wdata = (state == REFILL) ? mem_rdata : mem_wdata;
  assign cpu_stall   = cpu_req && (((state == IDLE) && (!hit || cpu_we)) ||
                                   (state == REFILL) || (state == WRITE));
  cache_line_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .word  (look),
    .hit   (hit),
    .rdata (cpu_rdata),
    .we    (store_we),
    .wdata (store_wdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req && (cpu_we || !hit)) begin
          state     <= cpu_we ? WRITE : REFILL;
          mem_req   <= 1'b1;
          mem_we    <= cpu_we;
          mem_addr  <= word_align(cpu_addr);
          mem_wdata <= cpu_we ? cpu_wdata : '0;
          if (!cpu_we) miss_cnt <= miss_cnt + 16'd1;
        end
        REFILL, WRITE: if (mem_ack) begin
          state     <= (state == WRITE) ? WDONE : IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scenario tasks with a read-data and memory-write scoreboard for cache_ctrl
module tb_cache_ctrl;
  logic        clk = 0, rst = 0, cpu_req = 0, cpu_we = 0, flush = 0, mem_ack = 0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, mem_req, mem_we;
  logic [15:0] miss_cnt;
  int checks = 0, failures = 0;
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
  );

  // memory acks n cycles after mem_req is first seen; optional flush on the first ack
  task automatic read_access(input logic [31:0] addr, input int n, input logic [31:0] data,
                             input bit flush_ack, output int stalls, output logic [31:0] rdata,
                             output logic [31:0] req_addr, output bit timeout);
    int reqcyc;
    bit flushed;
    stalls = 0; reqcyc = 0; flushed = 0; timeout = 1; rdata = '0; req_addr = '0;
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = addr;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!cpu_stall) begin rdata = cpu_rdata; timeout = 0; break; end
      stalls++;
      reqcyc = mem_req ? reqcyc + 1 : 0;
      if (reqcyc == n + 1) begin
        mem_ack = 1; mem_rdata = data; req_addr = mem_addr;
        if (flush_ack && !flushed) begin flush = 1; flushed = 1; end
      end
      @(negedge clk); mem_ack = 0; flush = 0; mem_rdata = '0;
    end
    @(negedge clk); cpu_req = 0;
  endtask

  task automatic write_access(input logic [31:0] addr, input logic [31:0] data, input int n,
                              output bit we_ok, output logic [31:0] ma, output logic [31:0] md,
                              output bit wdone_ok, output bit timeout);
    int reqcyc;
    reqcyc = 0; we_ok = 1; wdone_ok = 0; timeout = 1; ma = '0; md = '0;
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = addr; cpu_wdata = data;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!cpu_stall) begin wdone_ok = !mem_req; timeout = 0; break; end
      if (mem_req && !mem_we) we_ok = 0;
      reqcyc = mem_req ? reqcyc + 1 : 0;
      if (reqcyc == n + 1) begin mem_ack = 1; ma = mem_addr; md = mem_wdata; end
      @(negedge clk); mem_ack = 0;
    end
    @(negedge clk); cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (miss_cnt !== 16'h0) begin failures++; $display("FAIL reset_miss_cnt got %h want 0", miss_cnt); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got %b want 0", cpu_stall); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_read_miss();
    int s; logic [31:0] rd, ra, exp; bit to;
    rd_q.push_back(32'hDEADBEEF);
    read_access(32'h10, 3, 32'hDEADBEEF, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (to) begin failures++; $display("FAIL miss_timeout got timeout want completion"); end
    checks++; if (ra !== 32'h10) begin failures++; $display("FAIL miss_mem_addr got %h want 00000010", ra); end
    checks++; if (s !== 5) begin failures++; $display("FAIL miss_stall_len got %0d want 5", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL miss_rdata got %h want %h", rd, exp); end
    checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL miss_cnt got %0d want 1", miss_cnt); end
  endtask

  task automatic test_read_hit();
    int s; logic [31:0] rd, ra, exp; bit to;
    rd_q.push_back(32'hDEADBEEF);
    read_access(32'h10, 3, 32'h0BAD0BAD, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 0) begin failures++; $display("FAIL hit_stall got %0d want 0", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL hit_rdata got %h want %h", rd, exp); end
    checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL hit_miss_cnt got %0d want 1", miss_cnt); end
  endtask

  task automatic test_conflict();
    int s; logic [31:0] rd, ra, exp; bit to;
    rd_q.push_back(32'hCAFE0030);
    read_access(32'h30, 2, 32'hCAFE0030, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 4) begin failures++; $display("FAIL conflict_stall got %0d want 4", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL conflict_rdata got %h want %h", rd, exp); end
    rd_q.push_back(32'hDEADBEEF);
    read_access(32'h10, 1, 32'hDEADBEEF, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 3) begin failures++; $display("FAIL conflict_remiss_stall got %0d want 3", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL conflict_remiss_rdata got %h want %h", rd, exp); end
    checks++; if (miss_cnt !== 16'd3) begin failures++; $display("FAIL conflict_miss_cnt got %0d want 3", miss_cnt); end
  endtask

  task automatic test_write_hit();
    int s; logic [31:0] rd, ra, ma, md, exp; logic [63:0] ew; bit to, we_ok, wd;
    wr_q.push_back({32'h10, 32'h1234});
    write_access(32'h10, 32'h1234, 2, we_ok, ma, md, wd, to);
    ew = wr_q.pop_front();
    checks++; if (to) begin failures++; $display("FAIL wr_hit_timeout got timeout want completion"); end
    checks++; if ({ma, md} !== ew) begin failures++; $display("FAIL wr_hit_mem got %h want %h", {ma, md}, ew); end
    checks++; if (!we_ok) begin failures++; $display("FAIL wr_hit_mem_we got 0 want 1 while mem_req"); end
    checks++; if (!wd) begin failures++; $display("FAIL wr_hit_wdone got mem_req=1 want 0 in unstalled cycle"); end
    rd_q.push_back(32'h1234);
    read_access(32'h10, 3, 32'hBADBAD00, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 0) begin failures++; $display("FAIL wr_hit_reread_stall got %0d want 0", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL wr_hit_reread_rdata got %h want %h", rd, exp); end
  endtask

  task automatic test_write_miss();
    int s; logic [31:0] rd, ra, ma, md, exp; logic [63:0] ew; bit to, we_ok, wd;
    wr_q.push_back({32'h80, 32'h5555AAAA});
    write_access(32'h83, 32'h5555AAAA, 1, we_ok, ma, md, wd, to);
    ew = wr_q.pop_front();
    checks++; if ({ma, md} !== ew) begin failures++; $display("FAIL wr_miss_mem got %h want %h", {ma, md}, ew); end
    rd_q.push_back(32'h77777777);
    read_access(32'h80, 1, 32'h77777777, 0, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 3) begin failures++; $display("FAIL wr_miss_noalloc_stall got %0d want 3", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL wr_miss_read_rdata got %h want %h", rd, exp); end
    checks++; if (miss_cnt !== 16'd4) begin failures++; $display("FAIL wr_miss_cnt got %0d want 4", miss_cnt); end
  endtask

  task automatic test_flush_on_ack();
    int s; logic [31:0] rd, ra, exp; bit to;
    rd_q.push_back(32'h20202020);
    read_access(32'h20, 3, 32'h20202020, 1, s, rd, ra, to);
    exp = rd_q.pop_front();
    checks++; if (s !== 10) begin failures++; $display("FAIL flush_ack_stall got %0d want 10", s); end
    checks++; if (rd !== exp) begin failures++; $display("FAIL flush_ack_rdata got %h want %h", rd, exp); end
    checks++; if (miss_cnt !== 16'd6) begin failures++; $display("FAIL flush_ack_miss_cnt got %0d want 6", miss_cnt); end
  endtask

  task automatic test_flush();
    int s; logic [31:0] rd, ra; bit to;
    read_access(32'h20, 1, 32'h0, 0, s, rd, ra, to);
    checks++; if (s !== 0) begin failures++; $display("FAIL preflush_hit_stall got %0d want 0", s); end
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    rd_q.push_back(32'h21212121);
    read_access(32'h20, 1, 32'h21212121, 0, s, rd, ra, to);
    checks++; if (s !== 3) begin failures++; $display("FAIL flush_remiss_stall got %0d want 3", s); end
    checks++; if (rd !== rd_q.pop_front()) begin failures++; $display("FAIL flush_remiss_rdata got %h want 21212121", rd); end
  endtask

  task automatic test_rst_refill();
    bit seen;
    seen = 0;
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (mem_req) begin seen = 1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_refill_req got no mem_req want mem_req"); end
    checks++; if (miss_cnt !== 16'd8) begin failures++; $display("FAIL rst_refill_pre_cnt got %0d want 8", miss_cnt); end
    @(negedge clk); rst = 1; cpu_req = 0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_refill_mem_req got %b want 0", mem_req); end
    checks++; if (miss_cnt !== 16'd0) begin failures++; $display("FAIL rst_refill_miss_cnt got %0d want 0", miss_cnt); end
    @(negedge clk); rst = 0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_conflict();
    test_write_hit();
    test_write_miss();
    test_flush_on_ack();
    test_flush();
    test_rst_refill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
